// File: rtl/output_drain_if.sv
// output_drain_if: element stream from the output drain to its consumer.
//   out_data  - current streamed element (DATA_W)
//   out_valid - out_data is valid
//   out_ready - consumer accepts out_data; transfer on out_valid && out_ready
//   out_index - element position within the 2x2 matrix (0=c00 .. 3=c11)
//   out_last  - high with out_valid on the final element (out_index == 3)
// modport master: producer side (output_drain); modport slave: consumer side.
interface output_drain_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_index;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/output_drain.sv
// output_drain: buffers whole 2x2 result matrices in a DEPTH-slot circular FIFO
// and streams them out element by element (c00, c01, c10, c11) over a
// valid/ready handshake.
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   capture, c00..c11   - one-cycle pulse loading a complete result matrix
//   stream (master)     - out_data/out_valid/out_ready/out_index/out_last
//   busy                - registered, high while any slot is occupied
//   overflow            - sticky, a capture was dropped on a full FIFO
//   overflow_clr        - clears overflow (a same-cycle drop wins)
// Build option: define OUTPUT_DRAIN_RELU_EN to zero negative elements on
// out_data (combinational on the output, no added latency).
module output_drain #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic [DATA_W-1:0] c00,
  input  logic [DATA_W-1:0] c01,
  input  logic [DATA_W-1:0] c10,
  input  logic [DATA_W-1:0] c11,
  output_drain_if.master    stream,
  output logic              busy,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] c00;
    logic [DATA_W-1:0] c01;
    logic [DATA_W-1:0] c10;
    logic [DATA_W-1:0] c11;
  } mat_t;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state;
  mat_t               slots [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_nxt;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  head_c00;
  logic [1:0]         index_q;
  logic               valid_q;
  logic               last_q;
  logic               xfer;
  logic               pop;
  logic               full;
  logic               accept;
  logic               drop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] elem(input mat_t m, input logic [1:0] i);
    case (i)
      2'd0:    return m.c00;
      2'd1:    return m.c01;
      2'd2:    return m.c10;
      default: return m.c11;
    endcase
  endfunction

  // Handshake decode and FIFO bookkeeping.
  // A capture on a full FIFO is still accepted when the head slot is freed
  // by its final transfer in the same cycle.
  always_comb begin
    xfer       = valid_q && stream.out_ready;
    pop        = xfer && last_q;
    full       = (count == CNT_W'(DEPTH));
    accept     = capture && (!full || pop);
    drop       = capture && full && !pop;
    count_nxt  = count + CNT_W'(accept) - CNT_W'(pop);
    rd_ptr_nxt = wrap_inc(rd_ptr);
    // The next head may be the slot being written this very cycle.
    head_c00   = (accept && (wr_ptr == rd_ptr_nxt)) ? c00 : slots[rd_ptr_nxt].c00;
  end

  // Slot storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      slots[wr_ptr] <= '{c00: c00, c01: c01, c10: c10, c11: c11};
    end
  end

  // FSM, pointers, flags and registered stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      valid_q  <= 1'b0;
      index_q  <= 2'd0;
      last_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      count <= count_nxt;
      busy  <= (count_nxt != '0);
      if (accept) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)    rd_ptr <= rd_ptr_nxt;

      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            state   <= STREAM;
            valid_q <= 1'b1;
            index_q <= 2'd0;
            last_q  <= 1'b0;
            data_q  <= c00;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (!last_q) begin
              index_q <= index_q + 2'd1;
              last_q  <= (index_q == 2'd2);
              data_q  <= elem(slots[rd_ptr], index_q + 2'd1);
            end else if (count_nxt != '0) begin
              // Roll straight into the next slot without a bubble.
              index_q <= 2'd0;
              last_q  <= 1'b0;
              data_q  <= head_c00;
            end else begin
              state   <= IDLE;
              valid_q <= 1'b0;
              index_q <= 2'd0;
              last_q  <= 1'b0;
              data_q  <= '0;
            end
          end
        end
      endcase
    end
  end

  assign stream.out_valid = valid_q;
  assign stream.out_index = index_q;
  assign stream.out_last  = last_q;

`ifdef OUTPUT_DRAIN_RELU_EN
  assign stream.out_data = data_q[DATA_W-1] ? '0 : data_q;
`else
  assign stream.out_data = data_q;
`endif

endmodule
